// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, recovered byte and status strobes out.
// The receiver drives through master; the downstream consumer connects as slave.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (input rx, output data, valid, frame_err, busy);
    modport slave  (output rx, input data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling from a clk/BAUD divider.
// Optionally removes the transmitter's +48 ASCII offset from each byte.
module uart_rx #(
    parameter int BAUD  = 115200,
    parameter int F     = 50000000,
    parameter int ASCII = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int P  = F / BAUD;
    localparam int H  = P / 2;
    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(P - 1);

    generate
        if (P < 8) begin : g_bad_div
            $error("uart_rx: F/BAUD must be at least 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, DONE, WAIT_HIGH
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          stop_bit, stop_n;
    logic [7:0]    data, data_n;
    logic          valid, valid_n;
    logic          ferr, ferr_n;
    logic          sync1, rx_s;
    logic [7:0]    adj;

    // Two-flop synchronizer; idle-high reset value so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= bus.rx;
            rx_s  <= sync1;
        end
    end

    assign adj = (ASCII != 0) ? (sh - 8'd48) : sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '0;
            stop_bit <= 1'b0;
            data     <= 8'h00;
            valid    <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            sh       <= sh_n;
            stop_bit <= stop_n;
            data     <= data_n;
            valid    <= valid_n;
            ferr     <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        stop_n  = stop_bit;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, sh[7:1]};
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    stop_n  = rx_s;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                // Strobes are issued one cycle after the stop sample, as busy drops.
                if (stop_bit) begin
                    data_n  = adj;
                    valid_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    ferr_n  = 1'b1;
                    state_n = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.data      = data;
    assign bus.valid     = valid;
    assign bus.frame_err = ferr;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at P=10, H=5 with raw and ASCII-adjusted instances.
module tb_uart_rx;
    localparam int F    = 1000000;
    localparam int BAUD = 100000;
    localparam int P    = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_line = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if b0 ();
    uart_rx_if b1 ();
    assign b0.rx = rx_line;
    assign b1.rx = rx_line;

    uart_rx #(.BAUD(BAUD), .F(F), .ASCII(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    uart_rx #(.BAUD(BAUD), .F(F), .ASCII(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: edge counter plus strobe and busy-edge capture, sampled 1 ns after each edge.
    int         cyc = 0;
    int         vq_cyc[$];
    logic [7:0] vq_dat[$];
    logic [7:0] vq_dat1[$];
    int         ferr_cnt = 0;
    int         ferr1_cnt = 0;
    int         ferr_cyc = 0;
    int         busy_rise = 0;
    int         busy_fall = 0;
    int         overlap = 0;
    logic       busy_q = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (b0.valid) begin
            vq_cyc.push_back(cyc);
            vq_dat.push_back(b0.data);
        end
        if (b1.valid) vq_dat1.push_back(b1.data);
        if (b0.frame_err) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (b1.frame_err) ferr1_cnt++;
        if ((b0.valid && b0.frame_err) || (b1.valid && b1.frame_err)) overlap++;
        if (b0.busy && !busy_q) busy_rise = cyc;
        if (!b0.busy && busy_q) busy_fall = cyc;
        busy_q = b0.busy;
    end

    task automatic clear_mon();
        vq_cyc.delete();
        vq_dat.delete();
        vq_dat1.delete();
        ferr_cnt  = 0;
        ferr1_cnt = 0;
    endtask

    // Called at a negedge; returns e0, the edge at which the first sync flop sees start.
    task automatic send(input logic [7:0] b, input logic stop_lvl, output int e0);
        e0 = cyc + 1;
        rx_line = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (P) @(negedge clk);
        end
        rx_line = stop_lvl;
        repeat (P) @(negedge clk);
        rx_line = 1'b1;
        if (!stop_lvl) rx_line = 1'b0;
    endtask

    int e0, e1, k;

    initial begin
        repeat (3) @(negedge clk);
        check("rst data0", b0.data, 8'h00);
        check("rst data1", b1.data, 8'h00);
        check("rst valid", {b0.valid, b1.valid}, 2'b00);
        check("rst ferr", {b0.frame_err, b1.frame_err}, 2'b00);
        check("rst busy", {b0.busy, b1.busy}, 2'b00);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame and latency
        clear_mon();
        send(8'hA5, 1'b1, e0);
        repeat (5) @(negedge clk);
        check("A5 count", vq_cyc.size(), 1);
        check("A5 latency", vq_cyc[0] - e0, 98);
        check("A5 data0", vq_dat[0], 8'hA5);
        check("A5 data1", vq_dat1[0], 8'h75);
        check("A5 busy rise", busy_rise - e0, 2);
        check("A5 busy fall", busy_fall - e0, 98);
        check("A5 ferr", ferr_cnt, 0);

        // ASCII offset removal, including wraparound
        clear_mon();
        send(8'h37, 1'b1, e0);
        repeat (5) @(negedge clk);
        check("37 count1", vq_dat1.size(), 1);
        check("37 data1", vq_dat1[0], 8'h07);
        check("37 data0", vq_dat[0], 8'h37);
        clear_mon();
        send(8'h20, 1'b1, e0);
        repeat (5) @(negedge clk);
        check("20 data1", vq_dat1[0], 8'hF0);
        check("20 data0", vq_dat[0], 8'h20);

        // 3-cycle glitch on idle line
        clear_mon();
        e0 = cyc + 1;
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch valid", vq_cyc.size(), 0);
        check("glitch ferr", ferr_cnt, 0);
        check("glitch busy rise", busy_rise - e0, 2);
        check("glitch busy fall", busy_fall - e0, 7);
        check("glitch idle", b0.busy, 1'b0);

        // Stop bit low, line held low, then recovery
        clear_mon();
        send(8'h55, 1'b0, e0);
        repeat (50) @(negedge clk);
        check("ferr count0", ferr_cnt, 1);
        check("ferr count1", ferr1_cnt, 1);
        check("ferr time", ferr_cyc - e0, 98);
        check("ferr no valid", vq_cyc.size(), 0);
        check("ferr hold data0", b0.data, 8'h20);
        check("ferr hold data1", b1.data, 8'hF0);
        check("ferr wait busy", b0.busy, 1'b1);
        k = cyc;
        rx_line = 1'b1;
        repeat (6) @(negedge clk);
        check("wait exit", busy_fall - k, 3);
        clear_mon();
        send(8'h3C, 1'b1, e0);
        repeat (5) @(negedge clk);
        check("3C count", vq_cyc.size(), 1);
        check("3C data0", vq_dat[0], 8'h3C);
        check("3C data1", vq_dat1[0], 8'h0C);

        // Back-to-back frames
        clear_mon();
        send(8'h01, 1'b1, e0);
        send(8'hFE, 1'b1, e1);
        repeat (5) @(negedge clk);
        check("b2b count", vq_cyc.size(), 2);
        check("b2b spacing", vq_cyc[1] - vq_cyc[0], 100);
        check("b2b first lat", vq_cyc[0] - e0, 98);
        check("b2b data0a", vq_dat[0], 8'h01);
        check("b2b data0b", vq_dat[1], 8'hFE);
        check("b2b data1a", vq_dat1[0], 8'hD1);
        check("b2b data1b", vq_dat1[1], 8'hCE);

        // Reset during bit 4 of a frame carrying 8'hF0
        clear_mon();
        rx_line = 1'b0;
        repeat (5 * P) @(negedge clk);
        rx_line = 1'b1;
        rst = 1'b0;
        #1;
        check("abort data0", b0.data, 8'h00);
        check("abort data1", b1.data, 8'h00);
        check("abort busy", {b0.busy, b1.busy}, 2'b00);
        repeat (5 * P) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h81, 1'b1, e0);
        repeat (5) @(negedge clk);
        check("81 count", vq_cyc.size(), 1);
        check("81 data0", vq_dat[0], 8'h81);
        check("81 data1", vq_dat1[0], 8'h51);
        check("81 ferr", ferr_cnt + ferr1_cnt, 0);
        check("strobe overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
